eusci_uart_tx: RTL and testbench

//  eUSCI_A UART transmit engine. Sits directly downstream of the baud-rate prescaler and uses its

---
 rtl/eusci_uart_pkg.sv | 22 ++
 rtl/uart_tick_detect.sv | 22 ++
 rtl/eusci_uart_tx.sv | 153 +++++++++++++++
 tb/tb_eusci_uart_tx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/eusci_uart_pkg.sv
// Shared eUSCI_A UART definitions for the TX engine and the future RX engine.
// StPar exists only when UART_TX_PARITY_EN is defined.
package eusci_uart_pkg;

    localparam int unsigned BITS_8 = 8;
    localparam int unsigned BITS_7 = 7;

    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
`ifdef UART_TX_PARITY_EN
        StPar   = 3'd3,
`endif
        StStop1 = 3'd4,
        StStop2 = 3'd5
    } uart_state_e;

endpackage

// File: rtl/uart_tick_detect.sv
// Bit-period tick from the prescaler: rising edge of ScaleCLK, or every cycle in passthrough.
module uart_tick_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_scale_clk,
    input  logic i_brpass,
    output logic o_tick
);

    logic r_scale_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_scale_q <= 1'b0;
        end else begin
            r_scale_q <= i_scale_clk;
        end
    end

    assign o_tick = i_brpass | (i_scale_clk & ~r_scale_q);

endmodule

// File: rtl/eusci_uart_tx.sv
// eUSCI_A UART transmitter: one-byte buffer feeding start/data/[parity]/stop frames on UCA0TXD.
// Parity framing is built only when UART_TX_PARITY_EN is defined.
module eusci_uart_tx
    import eusci_uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              BRCLK,
    input  logic              reset,
    input  logic              UCABEN,
    input  logic              ScaleCLK,
    input  logic              BRPASS,
    input  logic [DATA_W-1:0] txbuf_data,
    input  logic              txbuf_wr,
    input  logic              UC7BIT,
    input  logic              UCMSB,
    input  logic              UCSPB,
    input  logic              UCPEN,
    input  logic              UCPAR,
    output logic              UCA0TXD,
    output logic              UCTXIFG,
    output logic              UCBUSY,
    output logic              tx_done
);

    localparam int unsigned    CNT_W     = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_SHORT = CNT_W'(DATA_W - 1);

    uart_state_e       r_state, w_state_next;
    logic [DATA_W-1:0] r_buf, r_shift, w_shift_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic              r_buf_full, r_txd, w_txd_next, r_done, r_msb, r_spb;
    logic              w_tick, w_wr_ok, w_frame_end, w_load, w_send, w_bit;
    logic              w_par_en, w_par_bit;

    uart_tick_detect u_tick (
        .i_clk       (BRCLK),
        .i_reset     (reset),
        .i_scale_clk (ScaleCLK),
        .i_brpass    (BRPASS),
        .o_tick      (w_tick)
    );

    assign w_wr_ok     = txbuf_wr & ~r_buf_full;
    assign w_frame_end = w_tick & (((r_state == StStop1) && (r_spb == STOP_1))
                                   || (r_state == StStop2));
    // A buffered byte starts on an idle tick or chains straight off the closing stop tick.
    assign w_load      = r_buf_full & ((w_tick & (r_state == StIdle)) | w_frame_end);
    assign w_send      = w_tick & ~w_load
                         & ((r_state == StStart) | ((r_state == StData) & (r_cnt != '0)));
    assign w_bit       = r_msb ? r_shift[DATA_W-1] : r_shift[0];

`ifdef UART_TX_PARITY_EN
    logic r_pen, r_par_sel, r_par_acc;

    always_ff @(posedge BRCLK) begin
        if (reset || !UCABEN) begin
            r_pen     <= 1'b0;
            r_par_sel <= 1'b0;
            r_par_acc <= 1'b0;
        end else if (w_load) begin
            r_pen     <= UCPEN;
            r_par_sel <= UCPAR;
            r_par_acc <= 1'b0;
        end else if (w_send) begin
            r_par_acc <= r_par_acc ^ w_bit;
        end
    end

    assign w_par_en  = r_pen;
    assign w_par_bit = r_par_acc ^ ~r_par_sel;
`else
    logic w_unused_par;
    assign w_unused_par = UCPEN ^ UCPAR;
    assign w_par_en     = 1'b0;
    assign w_par_bit    = 1'b1;
`endif

    always_ff @(posedge BRCLK) begin
        if (reset || !UCABEN) begin
            r_state    <= StIdle;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_txd      <= 1'b1;
            r_done     <= 1'b0;
            r_msb      <= 1'b0;
            r_spb      <= STOP_1;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_cnt   <= w_cnt_next;
            r_txd   <= w_txd_next;
            r_done  <= w_frame_end;
            if (w_wr_ok) begin
                r_buf      <= txbuf_data;
                r_buf_full <= 1'b1;
            end else if (w_load) begin
                r_buf_full <= 1'b0;
            end
            if (w_load) begin
                r_msb <= UCMSB;
                r_spb <= UCSPB;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_load) begin
            w_state_next = StStart;
        end else if (w_tick) begin
            unique case (r_state)
                StStart: w_state_next = StData;
`ifdef UART_TX_PARITY_EN
                StData:  if (r_cnt == '0) w_state_next = w_par_en ? StPar : StStop1;
                StPar:   w_state_next = StStop1;
`else
                StData:  if (r_cnt == '0) w_state_next = StStop1;
`endif
                StStop1: w_state_next = (r_spb == STOP_2) ? StStop2 : StIdle;
                StStop2: w_state_next = StIdle;
                default: w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_txd_next   = r_txd;
        w_shift_next = r_shift;
        w_cnt_next   = r_cnt;
        if (w_load) begin
            w_txd_next   = 1'b0;
            // 7-bit MSB-first: left-align so bit 6 leaves first from the top.
            w_shift_next = (UCMSB & UC7BIT) ? {r_buf[DATA_W-2:0], 1'b0} : r_buf;
            w_cnt_next   = UC7BIT ? CNT_SHORT : CNT_FULL;
        end else if (w_send) begin
            w_txd_next   = w_bit;
            w_shift_next = r_msb ? {r_shift[DATA_W-2:0], 1'b0} : {1'b0, r_shift[DATA_W-1:1]};
            w_cnt_next   = r_cnt - 1'b1;
        end else if (w_tick) begin
            w_txd_next = ((r_state == StData) && w_par_en) ? w_par_bit : 1'b1;
        end
    end

    assign UCA0TXD = r_txd;
    assign UCTXIFG = ~r_buf_full;
    assign UCBUSY  = (r_state != StIdle) | r_buf_full;
    assign tx_done = r_done;

endmodule

// File: tb/tb_eusci_uart_tx.sv
// Directed bench for eusci_uart_tx: frame shapes, back-to-back chaining, abort and passthrough.
module tb_eusci_uart_tx;

    logic       BRCLK = 1'b0;
    logic       reset, UCABEN, ScaleCLK, BRPASS, txbuf_wr;
    logic       UC7BIT, UCMSB, UCSPB, UCPEN, UCPAR;
    logic [7:0] txbuf_data;
    logic       UCA0TXD, UCTXIFG, UCBUSY, tx_done;
    logic [31:0] exp_v;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 BRCLK = ~BRCLK;

    eusci_uart_tx #(.DATA_W(8)) dut (
        .BRCLK      (BRCLK),
        .reset      (reset),
        .UCABEN     (UCABEN),
        .ScaleCLK   (ScaleCLK),
        .BRPASS     (BRPASS),
        .txbuf_data (txbuf_data),
        .txbuf_wr   (txbuf_wr),
        .UC7BIT     (UC7BIT),
        .UCMSB      (UCMSB),
        .UCSPB      (UCSPB),
        .UCPEN      (UCPEN),
        .UCPAR      (UCPAR),
        .UCA0TXD    (UCA0TXD),
        .UCTXIFG    (UCTXIFG),
        .UCBUSY     (UCBUSY),
        .tx_done    (tx_done)
    );

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // One ScaleCLK rising edge, check the registered result, then one low cycle.
    task automatic tick_chk(input logic exp_txd, input logic exp_done, input string tag);
        ScaleCLK = 1'b1;
        @(negedge BRCLK);
        ScaleCLK = 1'b0;
        check_eq({tag, "_txd"}, UCA0TXD, exp_txd);
        check_eq({tag, "_done"}, tx_done, exp_done);
        @(negedge BRCLK);
    endtask

    // Vectors are written in tick order, leftmost bit first.
    task automatic run_frame(input logic [31:0] txd_v, input logic [31:0] done_v, input int n,
                             input string tag);
        for (int i = 0; i < n; i++) begin
            tick_chk(txd_v[n-1-i], done_v[n-1-i], $sformatf("%s_t%0d", tag, i + 1));
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        txbuf_data = d;
        txbuf_wr   = 1'b1;
        @(negedge BRCLK);
        txbuf_wr   = 1'b0;
    endtask

    task automatic start_frame(input logic [7:0] d, input string tag);
        write_byte(d);
        check_eq({tag, "_ifg_wr"}, UCTXIFG, 1'b0);
        check_eq({tag, "_busy_wr"}, UCBUSY, 1'b1);
        tick_chk(1'b0, 1'b0, {tag, "_start"});
        check_eq({tag, "_ifg_start"}, UCTXIFG, 1'b1);
    endtask

    initial begin
        reset = 1'b1; UCABEN = 1'b1; ScaleCLK = 1'b0; BRPASS = 1'b0;
        txbuf_wr = 1'b0; txbuf_data = 8'h00;
        UC7BIT = 1'b0; UCMSB = 1'b0; UCSPB = 1'b0; UCPEN = 1'b0; UCPAR = 1'b0;
        repeat (3) @(negedge BRCLK);
        reset = 1'b0;
        check_eq("rst_txd", UCA0TXD, 1'b1);
        check_eq("rst_ifg", UCTXIFG, 1'b1);
        check_eq("rst_busy", UCBUSY, 1'b0);
        check_eq("rst_done", tx_done, 1'b0);
        @(negedge BRCLK);

        // 8N1 LSB-first 0x55
        start_frame(8'h55, "n81");
        run_frame(32'b10101010_1_1, 32'h1, 10, "n81");
        check_eq("n81_busy_end", UCBUSY, 1'b0);

        // 7-bit MSB-first 0x41; config flipped mid-frame must not matter
        UC7BIT = 1'b1; UCMSB = 1'b1;
        start_frame(8'h41, "m7");
        UC7BIT = 1'b0; UCMSB = 1'b0;
        run_frame(32'b1000001_1_1, 32'h1, 9, "m7");

        // Two stop bits
        UCSPB = 1'b1;
        start_frame(8'hFF, "s2");
        run_frame(32'b11111111_1_1_1, 32'h1, 11, "s2");
        UCSPB = 1'b0;

        // Parity enable: even then odd
        UCPEN = 1'b1; UCPAR = 1'b1;
        start_frame(8'h07, "pe");
`ifdef UART_TX_PARITY_EN
        run_frame(32'b11100000_1_1_1, 32'h1, 11, "pe");
`else
        run_frame(32'b11100000_1_1, 32'h1, 10, "pe");
`endif
        UCPAR = 1'b0;
        start_frame(8'h07, "po");
`ifdef UART_TX_PARITY_EN
        run_frame(32'b11100000_0_1_1, 32'h1, 11, "po");
`else
        run_frame(32'b11100000_1_1, 32'h1, 10, "po");
`endif
        UCPEN = 1'b0;

        // Back-to-back: 0xA5 then 0x3C chained, a third write dropped
        start_frame(8'hA5, "b2b");
        write_byte(8'h3C);
        check_eq("b2b_ifg_second", UCTXIFG, 1'b0);
        write_byte(8'hFF);
        check_eq("b2b_ifg_third", UCTXIFG, 1'b0);
        run_frame(32'b10100101_1_0_00111100_1_1, 32'b0000000001_0000000001, 20, "b2b");
        check_eq("b2b_ifg_end", UCTXIFG, 1'b1);
        check_eq("b2b_busy_end", UCBUSY, 1'b0);
        tick_chk(1'b1, 1'b0, "b2b_idle1");
        tick_chk(1'b1, 1'b0, "b2b_idle2");

        // Abort after data bit 3 with a second byte pending
        start_frame(8'h55, "ab");
        write_byte(8'hAA);
        run_frame(32'b1010, 32'h0, 4, "ab");
        check_eq("ab_busy_pre", UCBUSY, 1'b1);
        UCABEN = 1'b0;
        @(negedge BRCLK);
        check_eq("ab_txd", UCA0TXD, 1'b1);
        check_eq("ab_busy", UCBUSY, 1'b0);
        check_eq("ab_done", tx_done, 1'b0);
        check_eq("ab_ifg", UCTXIFG, 1'b1);
        UCABEN = 1'b1;
        @(negedge BRCLK);
        check_eq("ab_ifg_reen", UCTXIFG, 1'b1);
        run_frame(32'b111, 32'h0, 3, "ab_idle");

        // Passthrough: write lands on a tick cycle, so the frame starts one cycle later
        txbuf_data = 8'h55;
        txbuf_wr   = 1'b1;
        BRPASS     = 1'b1;
        @(negedge BRCLK);
        txbuf_wr   = 1'b0;
        check_eq("bp_ifg_wr", UCTXIFG, 1'b0);
        check_eq("bp_txd_wr", UCA0TXD, 1'b1);
        exp_v = 32'b0_10101010_1_1;
        for (int i = 0; i < 11; i++) begin
            @(negedge BRCLK);
            check_eq($sformatf("bp_txd_c%0d", i), UCA0TXD, exp_v[10-i]);
            check_eq($sformatf("bp_done_c%0d", i), tx_done, (i == 10));
        end
        BRPASS = 1'b0;
        @(negedge BRCLK);
        check_eq("bp_busy_end", UCBUSY, 1'b0);
        check_eq("bp_done_end", tx_done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
